// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit bus controller with alignment, lane steering and load extension
module lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_q_is_mem_read,
  input  logic            mem_q_is_mem_write,
  input  logic [2:0]      mem_q_funct3,
  input  logic [XLEN-1:0] mem_q_addr,
  input  logic [XLEN-1:0] mem_q_wdata,
  input  logic            mem_q_trap_valid,
  output logic            dmem_periph_req,
  output logic            mem_done_o,
  output logic [XLEN-1:0] mem_load_data_o,
  output logic            mem_misaligned_o,
  output logic            bus_req_o,
  input  logic            bus_gnt_i,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] rdata_q;
  logic access, go;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [XLEN-1:0] ld_ext;
  assign access = (mem_q_is_mem_read | mem_q_is_mem_write) & !mem_q_trap_valid;
  assign mem_misaligned_o = access & ((mem_q_funct3[1:0] == 2'b01 & mem_q_addr[0]) |
                                      (mem_q_funct3[1:0] == 2'b10 & |mem_q_addr[1:0]));
  assign go = access & !mem_misaligned_o;
  assign dmem_periph_req = (state == IDLE & go) | (state != IDLE);
  assign mem_done_o = state == DONE;
  assign bus_we_o = mem_q_is_mem_write;
  assign bus_addr_o = {mem_q_addr[XLEN-1:2], 2'b00};
  assign bus_be_o = !access ? 4'b0000 :
                    mem_q_funct3[1:0] == 2'b00 ? 4'b0001 << mem_q_addr[1:0] :
                    mem_q_funct3[1:0] == 2'b01 ? 4'b0011 << {mem_q_addr[1], 1'b0} : 4'b1111;
  assign bus_wdata_o = mem_q_funct3[1:0] == 2'b00 ? {4{mem_q_wdata[7:0]}} :
                       mem_q_funct3[1:0] == 2'b01 ? {2{mem_q_wdata[15:0]}} : mem_q_wdata;
  assign ld_byte = rdata_q[{mem_q_addr[1:0], 3'b000} +: 8];
  assign ld_half = rdata_q[{mem_q_addr[1], 4'b0000} +: 16];
  assign ld_ext = mem_q_funct3[1:0] == 2'b00 ? {{(XLEN-8){~mem_q_funct3[2] & ld_byte[7]}}, ld_byte} :
                  mem_q_funct3[1:0] == 2'b01 ? {{(XLEN-16){~mem_q_funct3[2] & ld_half[15]}}, ld_half} : rdata_q;
  assign mem_load_data_o = (mem_done_o & mem_q_is_mem_read & !mem_q_is_mem_write) ? ld_ext : '0;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  // capture the response only while waiting for it; stray rvalid elsewhere is dropped
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rdata_q <= '0;
    else if (state == WAIT_RSP && bus_rvalid_i) rdata_q <= bus_rdata_i;
  // next state and request; the bus fields are held by the stalled pipeline while in REQ
  always_comb begin
    state_nx = state;
    bus_req_o = 1'b0;
    case (state)
      IDLE: begin
        bus_req_o = go;
        if (go) state_nx = bus_gnt_i ? WAIT_RSP : REQ;
      end
      REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_nx = WAIT_RSP;
      end
      WAIT_RSP: if (bus_rvalid_i) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed-vector bench for lsu_ctrl
module tb_lsu_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd = 1'b0, wr = 1'b0, trap = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic periph, done, misal, req, we;
  logic [31:0] ldata, baddr, bwdata;
  logic [3:0] be;
  int n_tests = 0, n_fail = 0;
  lsu_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_q_is_mem_read(rd), .mem_q_is_mem_write(wr), .mem_q_funct3(f3),
    .mem_q_addr(addr), .mem_q_wdata(wdata), .mem_q_trap_valid(trap),
    .dmem_periph_req(periph), .mem_done_o(done), .mem_load_data_o(ldata),
    .mem_misaligned_o(misal), .bus_req_o(req), .bus_gnt_i(gnt), .bus_we_o(we),
    .bus_addr_o(baddr), .bus_be_o(be), .bus_wdata_o(bwdata),
    .bus_rvalid_i(rvalid), .bus_rdata_i(rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; f3 = f; addr = a; wdata = d;
  endtask
  // full transaction: grant in the request cycle, response one cycle later, done on the third cycle
  task automatic txn(input string tag, input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rsp, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    drive(r, w, f, a, d);
    gnt = 1'b1;
    @(negedge clk);
    check({tag, " c1 req"}, 32'(req), 32'd1);
    check({tag, " c1 periph"}, 32'(periph), 32'd1);
    check({tag, " be"}, 32'(be), 32'(exp_be));
    check({tag, " wdata"}, bwdata, exp_wd);
    check({tag, " addr"}, baddr, {a[31:2], 2'b00});
    check({tag, " we"}, 32'(we), 32'(w));
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = rsp;
    @(negedge clk);
    check({tag, " c2 req"}, 32'(req), 32'd0);
    check({tag, " c2 periph"}, 32'(periph), 32'd1);
    check({tag, " c2 done"}, 32'(done), 32'd0);
    step();
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    check({tag, " c3 done"}, 32'(done), 32'd1);
    check({tag, " c3 periph"}, 32'(periph), 32'd1);
    check({tag, " c3 req"}, 32'(req), 32'd0);
    check({tag, " load data"}, ldata, exp_ld);
    step();
  endtask
  initial begin
    #2;
    @(negedge clk);
    check("reset done", 32'(done), 32'd0);
    check("reset req", 32'(req), 32'd0);
    check("reset periph", 32'(periph), 32'd0);
    check("reset ldata", ldata, 32'd0);
    check("reset be", 32'(be), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    txn("LW 100", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("after LW idle", 32'(periph), 32'd0);
    step();
    txn("LB 103", 1, 0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'hFFFFFF80);
    txn("LBU 103", 1, 0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080);
    txn("LH 102", 1, 0, 3'b001, 32'h102, 0, 32'h8001ABCD, 4'b1100, 32'h0, 32'hFFFF8001);
    txn("LHU 100", 1, 0, 3'b101, 32'h100, 0, 32'h1234ABCD, 4'b0011, 32'h0, 32'h0000ABCD);
    txn("SB 101", 0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 4'b0010, 32'hABABABAB, 32'h0);
    drive(0, 0, 0, 0, 0);
    step();
    drive(0, 1, 3'b001, 32'h202, 32'h1234);
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("SH hold%0d req", i), 32'(req), 32'd1);
      check($sformatf("SH hold%0d be", i), 32'(be), 32'hC);
      check($sformatf("SH hold%0d wdata", i), bwdata, 32'h12341234);
      check($sformatf("SH hold%0d addr", i), baddr, 32'h200);
      check($sformatf("SH hold%0d we", i), 32'(we), 32'd1);
      step();
    end
    gnt = 1'b1;
    @(negedge clk);
    check("SH gnt req", 32'(req), 32'd1);
    step();
    gnt = 1'b0; rvalid = 1'b1;
    @(negedge clk);
    check("SH wait req", 32'(req), 32'd0);
    check("SH wait done", 32'(done), 32'd0);
    step();
    rvalid = 1'b0;
    @(negedge clk);
    check("SH done", 32'(done), 32'd1);
    check("SH ldata", ldata, 32'd0);
    step();
    drive(1, 0, 3'b010, 32'h101, 0);
    gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'(i);
      @(negedge clk);
      check($sformatf("MIS%0d misaligned", i), 32'(misal), 32'd1);
      check($sformatf("MIS%0d req", i), 32'(req), 32'd0);
      check($sformatf("MIS%0d periph", i), 32'(periph), 32'd0);
      check($sformatf("MIS%0d done", i), 32'(done), 32'd0);
      step();
    end
    gnt = 1'b0; rvalid = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("MIS cleared", 32'(misal), 32'd0);
    step();
    drive(1, 0, 3'b010, 32'h100, 0);
    trap = 1'b1;
    @(negedge clk);
    check("TRAP req", 32'(req), 32'd0);
    check("TRAP periph", 32'(periph), 32'd0);
    step();
    trap = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    check("RST start req", 32'(req), 32'd1);
    step();
    gnt = 1'b0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("RST async periph", 32'(periph), 32'd0);
    step();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("RST stray%0d done", i), 32'(done), 32'd0);
      check($sformatf("RST stray%0d periph", i), 32'(periph), 32'd0);
      check($sformatf("RST stray%0d req", i), 32'(req), 32'd0);
      check($sformatf("RST stray%0d ldata", i), ldata, 32'd0);
      step();
    end
    rvalid = 1'b0; rdata = 32'h0;
    drive(0, 1, 3'b010, 32'h300, 32'hCAFEF00D);
    gnt = 1'b1;
    @(negedge clk);
    check("B2B SW wdata", bwdata, 32'hCAFEF00D);
    step();
    gnt = 1'b0; rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    @(negedge clk);
    check("B2B SW done", 32'(done), 32'd1);
    check("B2B DONE no req", 32'(req), 32'd0);
    step();
    txn("B2B LW 304", 1, 0, 3'b010, 32'h304, 0, 32'h11223344, 4'b1111, 32'h0, 32'h11223344);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("final idle periph", 32'(periph), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The parameter list SHALL be: XLEN, default 32, data and address width; only 32 is supported.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_q_is_mem_read  in  1  MEM-stage instruction is a load
- mem_q_is_mem_write  in  1  MEM-stage instruction is a store
- mem_q_funct3  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- mem_q_addr  in  XLEN  effective byte address
- mem_q_wdata  in  XLEN  store data, low-aligned
- mem_q_trap_valid  in  1  MEM-stage instruction already carries a trap
- dmem_periph_req  out  1  access in progress; feeds the hazard stall
- mem_done_o  out  1  single-cycle completion pulse
- mem_load_data_o  out  XLEN  aligned, extended load result
- mem_misaligned_o  out  1  misaligned-access trap flag
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus request accepted
- bus_we_o  out  1  write enable
- bus_addr_o  out  XLEN  word-aligned address {addr[31:2],2'b00}
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  XLEN  lane-replicated store data
- bus_rvalid_i  in  1  response or write acknowledge
- bus_rdata_i  in  XLEN  response data

Function
REQ-004 The block SHALL define access = (is_mem_read | is_mem_write) & !mem_q_trap_valid.
REQ-005 mem_misaligned_o SHALL be combinational and asserted when access is set and either: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-006 The FSM SHALL have the states IDLE, REQ, WAIT_RSP, DONE.
REQ-007 IDLE: when access & !misaligned, the block SHALL assert bus_req_o; with bus_gnt_i it goes to WAIT_RSP, otherwise to REQ.
REQ-008 REQ: the block SHALL hold bus_req_o and all bus_* fields stable until bus_gnt_i, then go to WAIT_RSP.
REQ-009 WAIT_RSP: bus_req_o=0; on bus_rvalid_i the block SHALL capture bus_rdata_i and go to DONE.
REQ-010 DONE: mem_done_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; DONE never issues a request.
REQ-011 dmem_periph_req SHALL equal (IDLE & access & !misaligned) | (state != IDLE).
REQ-012 bus_rvalid_i SHALL be ignored in IDLE, REQ and DONE.
REQ-013 Minimum latency: grant in the request cycle, rvalid one cycle later, mem_done_o on the third cycle.
REQ-014 Byte enables SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; all-zero when there is no access.
REQ-015 bus_wdata_o SHALL be: byte replicated x4 for SB, halfword replicated x2 for SH, the word for SW; bus_we_o = is_mem_write.
REQ-016 mem_load_data_o SHALL select the byte or halfword by addr[1:0] from the captured data, sign-extend for LB/LH, zero-extend for LBU/LHU, pass the word for LW, and equal 0 for stores.
REQ-017 mem_load_data_o SHALL be valid only while mem_done_o=1.
REQ-018 The MEM-stage inputs SHALL be treated as stable from the first request cycle through DONE, because the pipeline is stalled.
REQ-019 A misaligned access or mem_q_trap_valid=1 SHALL produce no bus activity, and dmem_periph_req SHALL stay 0.

Reset
REQ-020 While rst_ni=0, the FSM SHALL be IDLE and the captured data register SHALL be 0, asynchronously.
REQ-021 Registered outputs SHALL reset to 0; combinational outputs then follow REQ-005, REQ-007, REQ-011, REQ-014 and REQ-015 from IDLE.
REQ-022 Reset mid-transaction SHALL abandon the access, and a later stray bus_rvalid_i SHALL be ignored in IDLE.

Verification
REQ-023 The bench SHALL cover LW at 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF -> mem_done_o on cycle 3, data 0xDEADBEEF, dmem_periph_req high on cycles 1-3.
REQ-024 The bench SHALL cover LB at 0x103 with rdata 0x80FFFFFF -> data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-025 The bench SHALL cover SH at 0x202 with wdata 0x1234, gnt delayed 3 cycles -> bus_be_o 4'b1100, bus_wdata_o 0x12341234, bus_addr_o 0x200, all held stable until gnt.
REQ-026 The bench SHALL cover LW at 0x101 -> mem_misaligned_o=1, bus_req_o=0, dmem_periph_req=0, mem_done_o never asserted.
REQ-027 The bench SHALL cover rst_ni low in WAIT_RSP, then rvalid -> FSM IDLE, no mem_done_o, outputs zero.
REQ-028 The bench SHALL cover back-to-back SW then LW -> no request issued in DONE; the second request starts in the IDLE cycle after DONE.
